sense_amp_seq: RTL and testbench

Clocked, parametrised successor to the combinational column sense amplifier. It sequences one SRAM read: bitline precharge, wordline-enabled bitline development, then a differential sense. It latches the per-column result and flags columns whose bitline split was too small to sense reliably. It sits between the analog bitline model (real-valued `bl_rd`/`blb_rd`) and the read data path, and drives precharge and wordline enables back to the array.

---
 rtl/sense_amp_seq.sv | 137 +++++++++++++
 tb/tb_sense_amp_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sense_amp_seq.sv
// sense_amp_seq
// Clocked column sense amplifier sequencer for one SRAM read.
// A read walks through bitline precharge, a wordline-on development window of
// DEV_CYCLES cycles, and a single sense cycle. On the edge that leaves SENSE
// every column's differential is resolved into a data bit. A column whose
// split is below VDIFF_MIN is flagged as weak. The array enables and the
// status flags are all registered.

module sense_amp_seq #(
   parameter int  COLS       = 16,
   parameter int  DEV_CYCLES = 2,
   parameter real VDD        = 1.5,
   parameter real VSS        = 0.0,
   parameter real VDIFF_MIN  = 0.1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rd_req,
   output logic            rd_busy,
   output logic            pre_en,
   output logic            wl_en,
   input  real             bl_rd  [0:COLS-1],
   input  real             blb_rd [0:COLS-1],
   output logic [COLS-1:0] dout,
   output real             preout [0:COLS-1],
   output logic [COLS-1:0] weak_err,
   output logic            rd_valid
);

   // The development counter only has to reach DEV_CYCLES-1. The width still
   // allows DEV_CYCLES itself, which keeps DEV_CYCLES=1 at a one-bit counter.
   localparam int CW = $clog2(DEV_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEV_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRECH   = 3'd1,
      S_DEVELOP = 3'd2,
      S_SENSE   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_pre;
   logic            r_wl;
   logic            r_valid;
   logic [COLS-1:0] r_dout;
   logic [COLS-1:0] r_weak;

   logic [COLS-1:0] w_senseHi;
   logic [COLS-1:0] w_senseWeak;

   // Per-column resolution of the analog bitline pair. Only the SENSE exit
   // edge stores these values, so bitline activity at other times has no effect.
   // A tie is not "greater", so an equal pair reads as 0. The weak test checks
   // both signs of the difference instead of taking an absolute value.
   for (genvar g = 0; g < COLS; g++) begin : g_col
      assign w_senseHi[g]   = (bl_rd[g] > blb_rd[g]);
      assign w_senseWeak[g] = ((bl_rd[g] - blb_rd[g]) < VDIFF_MIN) &&
                              ((blb_rd[g] - bl_rd[g]) < VDIFF_MIN);
      assign preout[g]      = r_dout[g] ? VDD : VSS;
   end

   // Read sequencer. The next-state logic and every registered output are
   // updated together in this block. Each output therefore changes on the same
   // edge as the state that owns it. pre_en and wl_en are owned by disjoint
   // states, so they can never be high together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_pre   <= 1'b0;
         r_wl    <= 1'b0;
         r_valid <= 1'b0;
         r_dout  <= '0;
         r_weak  <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (rd_req) begin
                  r_state <= S_PRECH;
                  r_pre   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_PRECH: begin
               r_state <= S_DEVELOP;
               r_pre   <= 1'b0;
               r_wl    <= 1'b1;
               r_cnt   <= '0;
            end
            S_DEVELOP: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_SENSE;
               end
            end
            S_SENSE: begin
               r_state <= S_DONE;
               r_wl    <= 1'b0;
               r_busy  <= 1'b0;
               r_valid <= 1'b1;
               r_dout  <= w_senseHi;
               r_weak  <= w_senseWeak;
            end
            S_DONE: begin
               if (rd_req) begin
                  r_state <= S_PRECH;
                  r_pre   <= 1'b1;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_pre   <= 1'b0;
               r_wl    <= 1'b0;
            end
         endcase
      end
   end

   assign rd_busy  = r_busy;
   assign pre_en   = r_pre;
   assign wl_en    = r_wl;
   assign rd_valid = r_valid;
   assign dout     = r_dout;
   assign weak_err = r_weak;

endmodule

// File: tb/tb_sense_amp_seq.sv
// tb_sense_amp_seq
// Directed bench for sense_amp_seq. The main instance uses DEV_CYCLES=2.
// Two more instances with DEV_CYCLES=1 and DEV_CYCLES=5 share its inputs and
// are only used to measure read latency.

module tb_sense_amp_seq;

   localparam int COLS = 16;

   logic clk;
   logic rst_n;
   logic rd_req;
   real  bl  [0:COLS-1];
   real  blb [0:COLS-1];

   logic            busy, preEn, wlEn, rdValid;
   logic [COLS-1:0] dout, weakErr;
   real             preout [0:COLS-1];

   logic            busy1, preEn1, wlEn1, rdValid1;
   logic [COLS-1:0] dout1, weakErr1;
   real             preout1 [0:COLS-1];

   logic            busy5, preEn5, wlEn5, rdValid5;
   logic [COLS-1:0] dout5, weakErr5;
   real             preout5 [0:COLS-1];

   int nVectors;
   int nMiscompares;
   int cycleNo;

   logic [3:0] seqExp [0:5];

   sense_amp_seq #(.COLS(COLS), .DEV_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req),
      .rd_busy(busy), .pre_en(preEn), .wl_en(wlEn),
      .bl_rd(bl), .blb_rd(blb),
      .dout(dout), .preout(preout), .weak_err(weakErr), .rd_valid(rdValid)
   );

   sense_amp_seq #(.COLS(COLS), .DEV_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req),
      .rd_busy(busy1), .pre_en(preEn1), .wl_en(wlEn1),
      .bl_rd(bl), .blb_rd(blb),
      .dout(dout1), .preout(preout1), .weak_err(weakErr1), .rd_valid(rdValid1)
   );

   sense_amp_seq #(.COLS(COLS), .DEV_CYCLES(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req),
      .rd_busy(busy5), .pre_en(preEn5), .wl_en(wlEn5),
      .bl_rd(bl), .blb_rd(blb),
      .dout(dout5), .preout(preout5), .weak_err(weakErr5), .rd_valid(rdValid5)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop so that a stuck design still ends the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one cycle and settle just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      cycleNo++;
   endtask

   // Single point for every comparison
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVectors++;
      if (got !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive bitlines: columns set in hiMask get 1.5/1.0, the rest get 1.0/1.5
   task automatic applyStimulus(input logic [COLS-1:0] hiMask);
      for (int i = 0; i < COLS; i++) begin
         bl[i]  = hiMask[i] ? 1.5 : 1.0;
         blb[i] = hiMask[i] ? 1.0 : 1.5;
      end
   endtask

   // Columns of the main instance's preout that sit exactly at lvl
   function automatic logic [COLS-1:0] levelMask(input real lvl);
      logic [COLS-1:0] m;
      m = '0;
      for (int i = 0; i < COLS; i++) m[i] = (preout[i] == lvl);
      return m;
   endfunction

   // Tick until rd_valid is seen, bounded
   task automatic waitValid(input string tag, output int at);
      at = -1;
      for (int n = 0; n < 20; n++) begin
         if (rdValid) begin
            at = cycleNo;
            break;
         end
         tick();
      end
      if (at < 0) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int e1, e2, lat1, lat2, lat5;
      nVectors     = 0;
      nMiscompares = 0;
      cycleNo      = 0;
      rst_n        = 1'b0;
      rd_req       = 1'b0;
      applyStimulus(16'h5555);
      seqExp = '{4'b1100, 4'b1010, 4'b1010, 4'b1010, 4'b0001, 4'b0000};

      // Reset state
      tick();
      tick();
      checkOutput("rst_ctl", {28'd0, busy, preEn, wlEn, rdValid}, 32'h0);
      checkOutput("rst_dout", {16'd0, dout}, 32'h0);
      checkOutput("rst_weak", {16'd0, weakErr}, 32'h0);
      checkOutput("rst_preout_vss", {16'd0, levelMask(0.0)}, 32'hFFFF);

      // Single read with alternating columns
      rst_n = 1'b1;
      tick();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      for (int j = 0; j < 6; j++) begin
         checkOutput($sformatf("rd1_ctl_%0d", j), {28'd0, busy, preEn, wlEn, rdValid}, {28'd0, seqExp[j]});
         if (j == 4) begin
            checkOutput("rd1_dout", {16'd0, dout}, 32'h5555);
            checkOutput("rd1_weak", {16'd0, weakErr}, 32'h0);
            checkOutput("rd1_preout_vdd", {16'd0, levelMask(1.5)}, 32'h5555);
            checkOutput("rd1_preout_vss", {16'd0, levelMask(0.0)}, 32'hAAAA);
         end
         if (j < 5) tick();
      end

      // Bitline change while idle does not disturb latched data
      applyStimulus(16'hAAAA);
      tick();
      tick();
      tick();
      checkOutput("hold_dout", {16'd0, dout}, 32'h5555);
      checkOutput("hold_preout", {16'd0, levelMask(1.5)}, 32'h5555);

      // Weak differential: col 3 0.75/0.70, col 5 exact tie
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
      checkOutput("weak_mid_dout", {16'd0, dout}, 32'h5555);
      applyStimulus(16'h5555);
      bl[3] = 0.75; blb[3] = 0.70;
      bl[5] = 0.8;  blb[5] = 0.8;
      waitValid("weak", e1);
      checkOutput("weak_dout", {16'd0, dout}, 32'h555D);
      checkOutput("weak_err", {16'd0, weakErr}, 32'h0028);
      applyStimulus(16'hAAAA);
      tick();
      tick();
      checkOutput("weak_hold", {16'd0, dout}, 32'h555D);

      // Back-to-back reads with rd_req held
      rd_req = 1'b1;
      tick();
      waitValid("b2b1", e1);
      tick();
      checkOutput("b2b_prech", {30'd0, busy, preEn}, 32'h3);
      waitValid("b2b2", e2);
      rd_req = 1'b0;
      checkOutput("b2b_spacing", e2 - e1, 32'd5);
      checkOutput("b2b_dout", {16'd0, dout}, 32'hAAAA);
      tick();
      checkOutput("b2b_idle", {28'd0, busy, preEn, wlEn, rdValid}, 32'h0);

      // Request during DEVELOP/SENSE is ignored
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
      rd_req = 1'b1;
      tick();
      tick();
      checkOutput("ign_sense", {28'd0, busy, preEn, wlEn, rdValid}, 32'b1010);
      tick();
      rd_req = 1'b0;
      checkOutput("ign_done", {28'd0, busy, preEn, wlEn, rdValid}, 32'b0001);
      tick();
      checkOutput("ign_idle1", {28'd0, busy, preEn, wlEn, rdValid}, 32'h0);
      tick();
      checkOutput("ign_idle2", {28'd0, busy, preEn, wlEn, rdValid}, 32'h0);

      // Reset during DEVELOP with rd_req held aborts the read
      rd_req = 1'b1;
      tick();
      tick();
      checkOutput("abort_wl_before", {31'd0, wlEn}, 32'h1);
      rst_n = 1'b0;
      tick();
      checkOutput("abort_ctl", {28'd0, busy, preEn, wlEn, rdValid}, 32'h0);
      checkOutput("abort_dout", {16'd0, dout}, 32'h0);
      checkOutput("abort_weak", {16'd0, weakErr}, 32'h0);
      checkOutput("abort_preout", {16'd0, levelMask(0.0)}, 32'hFFFF);
      for (int j = 0; j < 2; j++) begin
         tick();
         checkOutput($sformatf("abort_novalid_%0d", j), {31'd0, rdValid}, 32'h0);
      end
      rst_n  = 1'b1;
      rd_req = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tick();
         checkOutput($sformatf("abort_after_%0d", j), {31'd0, rdValid}, 32'h0);
      end

      // Latency for DEV_CYCLES 1, 2 and 5
      applyStimulus(16'h00FF);
      lat1 = -1; lat2 = -1; lat5 = -1;
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         tick();
         if (rdValid1 && lat1 < 0) lat1 = j;
         if (rdValid  && lat2 < 0) lat2 = j;
         if (rdValid5 && lat5 < 0) lat5 = j;
      end
      checkOutput("lat_dev1", lat1, 32'd3);
      checkOutput("lat_dev2", lat2, 32'd4);
      checkOutput("lat_dev5", lat5, 32'd7);
      checkOutput("lat_dout5", {16'd0, dout5}, 32'h00FF);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
